dm_ram_bytelane: RTL and testbench

Parametrised data memory for the pipelined MIPS datapath: DEPTH words of DWL bits, byte-addressed, with byte/half/word stores via lane enables and sign/zero-extended loads. Reads are registered (1-cycle latency), requests use a REQ/READY handshake, and illegal accesses (misaligned, out of range, bad size) are flagged instead of silently wrapping. After reset, a sweep state machine zero-fills the array before the block accepts traffic. Sits in the MEM stage, replacing the unbounded 32x32 array.

---
 rtl/dm_pkg.sv | 19 +
 rtl/dm_load_align.sv | 38 +++
 rtl/dm_ram_bytelane.sv | 145 ++++++++++++++
 tb/tb_dm_ram_bytelane.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the byte-lane data memory.
// Holds the SIZE encodings, the controller state type and the lane count.
// The data width is fixed at 32 bits for this generation, so there are
// always four byte lanes.
package dm_pkg;

   localparam int DM_DWL = 32;
   localparam int NLANES = DM_DWL / 8;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      ST_CLEAR,
      ST_IDLE
   } state_t;

endpackage

// File: rtl/dm_load_align.sv
// dm_load_align: combinational load alignment for the data memory.
// Picks the addressed byte or half-word out of a stored word (little-endian
// lanes) and sign- or zero-extends it to the full data width.
// Ports:
//   word   - raw word read from the array
//   offset - byte offset within the word (addr[1:0])
//   SIZE   - access size (byte / half / word)
//   UNS    - 1 = zero-extend, 0 = sign-extend
//   result - aligned and extended load value
module dm_load_align
   import dm_pkg::*;
#(
   parameter int DWL = 32
) (
   input  logic [DWL-1:0] word,
   input  logic [1:0]     offset,
   input  logic [1:0]     SIZE,
   input  logic           UNS,
   output logic [DWL-1:0] result
);

   logic [DWL-1:0] shifted;

   // Shifting by the byte offset brings the addressed byte (or the addressed
   // half, whose legal offsets are 0 and 2) down into the low lanes.
   always_comb begin
      shifted = word >> {offset, 3'b000};
      result  = shifted;
      case (SIZE)
         SZ_BYTE: result = UNS ? {{(DWL-8){1'b0}}, shifted[7:0]}
                               : {{(DWL-8){shifted[7]}}, shifted[7:0]};
         SZ_HALF: result = UNS ? {{(DWL-16){1'b0}}, shifted[15:0]}
                               : {{(DWL-16){shifted[15]}}, shifted[15:0]};
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/dm_ram_bytelane.sv
// dm_ram_bytelane: byte-addressed data memory for the MEM pipeline stage.
// DEPTH words of DWL bits, byte/half/word stores through lane enables,
// registered sign/zero-extended loads, REQ/READY handshake and fault
// reporting for misaligned, out-of-range or bad-size accesses.
// After reset a sweep zero-fills the array before READY is raised.
// Ports:
//   CLK, RST            - clock, asynchronous active-high reset
//   REQ, WR, SIZE, UNS  - request, store/load, access size, zero-extend
//   addr, Din           - byte address, store data
//   READY               - request can be accepted this cycle
//   VALID, FAULT, Dout  - one-cycle response for the previous accepted request
module dm_ram_bytelane
   import dm_pkg::*;
#(
   parameter int AWL   = 32,
   parameter int DWL   = 32,
   parameter int DEPTH = 64
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           REQ,
   input  logic           WR,
   input  logic [1:0]     SIZE,
   input  logic           UNS,
   input  logic [AWL-1:0] addr,
   input  logic [DWL-1:0] Din,
   output logic           READY,
   output logic           VALID,
   output logic           FAULT,
   output logic [DWL-1:0] Dout
);

   localparam int          IDXW  = $clog2(DEPTH);
   localparam logic [AWL:0] LIMIT = (AWL+1)'(DEPTH * 4);

   state_t            state, next_state;
   logic [IDXW-1:0]   clr_idx;
   logic [DWL-1:0]    mem [DEPTH];

   logic [IDXW-1:0]   word_idx;
   logic              accept;
   logic              fault;
   logic [NLANES-1:0] lane_be;
   logic [DWL-1:0]    store_data;
   logic [NLANES-1:0] wr_be;
   logic [IDXW-1:0]   wr_idx;
   logic [DWL-1:0]    wr_data;
   logic [DWL-1:0]    load_value;

   assign word_idx = addr[IDXW+1:2];
   assign READY    = (state == ST_IDLE);
   assign accept   = READY && REQ;

   // State register and sweep index; reset restarts the zero-fill from 0.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= ST_CLEAR;
         clr_idx <= '0;
      end else begin
         state <= next_state;
         if (state == ST_CLEAR)
            clr_idx <= clr_idx + 1'b1;
      end
   end

   // Leave CLEAR once the last word has been written.
   always_comb begin
      next_state = state;
      if (state == ST_CLEAR && clr_idx == IDXW'(DEPTH - 1))
         next_state = ST_IDLE;
   end

   // Fault decode. The range check is one bit wider than the address so a
   // memory that fills the whole address space never overflows the limit.
   always_comb begin
      fault = ({1'b0, addr} >= LIMIT);
      case (SIZE)
         SZ_BYTE: ;
         SZ_HALF: if (addr[0]) fault = 1'b1;
         SZ_WORD: if (addr[1:0] != 2'b00) fault = 1'b1;
         default: fault = 1'b1;
      endcase
   end

   // Lane enables and lane-replicated store data for a legal store.
   always_comb begin
      lane_be    = '0;
      store_data = Din;
      case (SIZE)
         SZ_BYTE: begin
            lane_be[addr[1:0]] = 1'b1;
            store_data         = {NLANES{Din[7:0]}};
         end
         SZ_HALF: begin
            lane_be    = addr[1] ? 4'b1100 : 4'b0011;
            store_data = {(NLANES/2){Din[15:0]}};
         end
         SZ_WORD: lane_be = '1;
         default: lane_be = '0;
      endcase
   end

   // Array write port is shared between the sweep and accepted stores.
   always_comb begin
      wr_be   = '0;
      wr_idx  = word_idx;
      wr_data = store_data;
      if (state == ST_CLEAR) begin
         wr_be   = '1;
         wr_idx  = clr_idx;
         wr_data = '0;
      end else if (accept && WR && !fault) begin
         wr_be = lane_be;
      end
   end

   // Array storage; not reset, the sweep takes care of initial contents.
   always_ff @(posedge CLK) begin
      for (int l = 0; l < NLANES; l++)
         if (wr_be[l])
            mem[wr_idx][l*8 +: 8] <= wr_data[l*8 +: 8];
   end

   dm_load_align #(.DWL(DWL)) u_align (
      .word   (mem[word_idx]),
      .offset (addr[1:0]),
      .SIZE   (SIZE),
      .UNS    (UNS),
      .result (load_value)
   );

   // Response registers; reset drops any in-flight response immediately.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         VALID <= 1'b0;
         FAULT <= 1'b0;
         Dout  <= '0;
      end else begin
         VALID <= accept;
         FAULT <= accept && fault;
         Dout  <= (accept && !fault && !WR) ? load_value : '0;
      end
   end

endmodule

// File: tb/tb_dm_ram_bytelane.sv
// tb_dm_ram_bytelane: directed bench for dm_ram_bytelane (DEPTH=64).
module tb_dm_ram_bytelane;
   import dm_pkg::*;

   logic        CLK;
   logic        RST;
   logic        REQ;
   logic        WR;
   logic [1:0]  SIZE;
   logic        UNS;
   logic [31:0] addr;
   logic [31:0] Din;
   logic        READY;
   logic        VALID;
   logic        FAULT;
   logic [31:0] Dout;

   int checks = 0;
   int errors = 0;
   int cycles;

   dm_ram_bytelane #(.AWL(32), .DWL(32), .DEPTH(64)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .REQ   (REQ),
      .WR    (WR),
      .SIZE  (SIZE),
      .UNS   (UNS),
      .addr  (addr),
      .Din   (Din),
      .READY (READY),
      .VALID (VALID),
      .FAULT (FAULT),
      .Dout  (Dout)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents one request, waits for the accepting edge and returns #1 later
   // so the response can be sampled.
   task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic uns,
                                input logic [31:0] a, input logic [31:0] d);
      REQ  = 1'b1;
      WR   = wr;
      SIZE = size;
      UNS  = uns;
      addr = a;
      Din  = d;
      @(posedge CLK);
      #1;
      REQ = 1'b0;
   endtask

   task automatic checkResponse(input string tag, input logic [31:0] data, input logic flt);
      checkOutput({tag, " valid"}, {31'b0, VALID}, 32'd1);
      checkOutput({tag, " fault"}, {31'b0, FAULT}, {31'b0, flt});
      checkOutput({tag, " dout"}, Dout, data);
   endtask

   // Counts edges from reset release until READY, bounded so it never hangs.
   task automatic waitReady(output int n);
      n = 0;
      while (!READY && n < 200) begin
         @(posedge CLK);
         #1;
         n++;
      end
   endtask

   task automatic releaseAndSweep(input string tag);
      @(posedge CLK);
      #2;
      RST = 1'b0;
      waitReady(cycles);
      checkOutput(tag, cycles, 32'd64);
   endtask

   initial begin
      RST = 1'b1; REQ = 1'b0; WR = 1'b0; SIZE = SZ_WORD; UNS = 1'b0;
      addr = '0; Din = '0;
      #1;
      checkOutput("reset ready", {31'b0, READY}, 32'd0);
      checkOutput("reset valid", {31'b0, VALID}, 32'd0);
      checkOutput("reset fault", {31'b0, FAULT}, 32'd0);
      checkOutput("reset dout", Dout, 32'd0);
      @(posedge CLK);
      releaseAndSweep("initial sweep cycles");

      // Fill with garbage, then reset and confirm the sweep cleared it.
      applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h3C, 32'hDEADBEEF);
      applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h40, 32'hA5A5A5A5);
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h3C, 32'h0);
      checkResponse("garbage readback", 32'hDEADBEEF, 1'b0);
      RST = 1'b1;
      #1;
      checkOutput("pulse ready low", {31'b0, READY}, 32'd0);
      releaseAndSweep("second sweep cycles");
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h3C, 32'h0);
      checkResponse("cleared 0x3C", 32'h0, 1'b0);

      // Word round-trip, back-to-back, then VALID drops.
      applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h4C, 32'h000000FA);
      checkResponse("store 0x4C", 32'h0, 1'b0);
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h4C, 32'h0);
      checkResponse("load 0x4C", 32'h000000FA, 1'b0);
      @(posedge CLK);
      #1;
      checkOutput("idle valid", {31'b0, VALID}, 32'd0);

      // Sub-word stores and extended loads.
      applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h40, 32'h11223344);
      applyStimulus(1'b1, SZ_BYTE, 1'b0, 32'h41, 32'h000000FB);
      checkResponse("byte store", 32'h0, 1'b0);
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
      checkResponse("merged word", 32'h1122FB44, 1'b0);
      applyStimulus(1'b0, SZ_BYTE, 1'b0, 32'h41, 32'h0);
      checkResponse("sbyte 0x41", 32'hFFFFFFFB, 1'b0);
      applyStimulus(1'b0, SZ_BYTE, 1'b1, 32'h41, 32'h0);
      checkResponse("ubyte 0x41", 32'h000000FB, 1'b0);
      applyStimulus(1'b0, SZ_HALF, 1'b0, 32'h42, 32'h0);
      checkResponse("shalf 0x42", 32'h00001122, 1'b0);
      applyStimulus(1'b0, SZ_HALF, 1'b0, 32'h40, 32'h0);
      checkResponse("shalf 0x40", 32'hFFFFFB44, 1'b0);
      applyStimulus(1'b0, SZ_HALF, 1'b1, 32'h40, 32'h0);
      checkResponse("uhalf 0x40", 32'h0000FB44, 1'b0);
      applyStimulus(1'b1, SZ_HALF, 1'b0, 32'h46, 32'h0000BEEF);
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h44, 32'h0);
      checkResponse("half lane hi", 32'hBEEF0000, 1'b0);
      applyStimulus(1'b0, SZ_BYTE, 1'b0, 32'h43, 32'h0);
      checkResponse("sbyte 0x43", 32'h00000011, 1'b0);

      // Faults.
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h42, 32'h0);
      checkResponse("misaligned word", 32'h0, 1'b1);
      applyStimulus(1'b1, SZ_HALF, 1'b0, 32'h41, 32'h0000AAAA);
      checkResponse("misaligned half store", 32'h0, 1'b1);
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
      checkResponse("unchanged after fault", 32'h1122FB44, 1'b0);
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0);
      checkResponse("out of range", 32'h0, 1'b1);
      applyStimulus(1'b1, SZ_BYTE, 1'b0, 32'h100, 32'h000000FF);
      checkResponse("oor store", 32'h0, 1'b1);
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
      checkResponse("no wrap to 0", 32'h0, 1'b0);
      applyStimulus(1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
      checkResponse("bad size", 32'h0, 1'b1);

      // Last word in range.
      applyStimulus(1'b1, SZ_WORD, 1'b0, 32'hFC, 32'hCAFEF00D);
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'hFC, 32'h0);
      checkResponse("last word", 32'hCAFEF00D, 1'b0);

      // Reset in the middle of the sweep restarts it.
      RST = 1'b1;
      @(posedge CLK);
      #2;
      RST = 1'b0;
      repeat (10) @(posedge CLK);
      #2;
      RST = 1'b1;
      #1;
      checkOutput("midsweep ready", {31'b0, READY}, 32'd0);
      releaseAndSweep("restarted sweep cycles");
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'hFC, 32'h0);
      checkResponse("cleared last word", 32'h0, 1'b0);

      // An in-flight response is dropped by an asynchronous reset.
      applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h12345678);
      applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
      checkOutput("pre-reset dout", Dout, 32'h12345678);
      RST = 1'b1;
      #1;
      checkOutput("dropped valid", {31'b0, VALID}, 32'd0);
      checkOutput("dropped dout", Dout, 32'd0);
      checkOutput("dropped ready", {31'b0, READY}, 32'd0);
      releaseAndSweep("final sweep cycles");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
